// File: rtl/fpadd_pipe_if.sv
// Operand/result bundle for the pipelined floating-point adder.
// The producer drives operands and the consumer's stop; the adder returns results and stopout.
interface fpadd_pipe_if #(
   parameter int EW = 11,
   parameter int FW = 52
) ();
   localparam int W = 1 + EW + FW;

   logic         pushin;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         stopin;
   logic         stopout;
   logic         pushout;
   logic [W-1:0] r;

   modport master (
      output pushin, op, a, b, stopin,
      input  stopout, pushout, r
   );

   modport slave (
      input  pushin, op, a, b, stopin,
      output stopout, pushout, r
   );
endinterface

// File: rtl/fpadd_pipe.sv
// Three-stage IEEE-754 adder/subtractor: unpack/align, add/normalise, round/pack.
// Denormals flush to zero, rounding is nearest-even, and stopin freezes the whole pipe.
module fpadd_pipe #(
   parameter int EW = 11,
   parameter int FW = 52
) (
   input  logic         clk,
   input  logic         rst_n,
   fpadd_pipe_if.slave  bus
);
   localparam int W  = 1 + EW + FW;
   localparam int SW = FW + 4;
   localparam int XW = EW + 2;
   localparam int LW = $clog2(SW + 1);
   localparam logic [EW-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(FW-1){1'b0}}};
   localparam logic signed [XW-1:0] EXP_INF = XW'((1 << EW) - 1);

   logic advance;
   assign advance     = !bus.stopin;
   assign bus.stopout = bus.stopin;

   // ---------------- stage 1: unpack, order by magnitude, align ----------------
   logic          sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
   logic [EW-1:0] ea, eb, big_exp, small_exp, ed;
   logic [FW-1:0] fa, fb;
   logic [EW+FW-1:0] mag_a, mag_b;
   logic [SW-1:0] sig_a, sig_b, big_sig, small_sig, small_shift, lost_mask;
   logic          big_sign, small_sign, nan_in, inf_in;
   logic [W-1:0]  special_word;

   always_comb begin
      sa = bus.a[W-1];
      ea = bus.a[W-2:FW];
      fa = bus.a[FW-1:0];
      sb = bus.b[W-1] ^ bus.op;
      eb = bus.b[W-2:FW];
      fb = bus.b[FW-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_nan  = (ea == EXP_ONES) && (fa != '0);
      b_nan  = (eb == EXP_ONES) && (fb != '0);
      a_inf  = (ea == EXP_ONES) && (fa == '0);
      b_inf  = (eb == EXP_ONES) && (fb == '0);
      sig_a  = a_zero ? '0 : {1'b1, fa, 3'b000};
      sig_b  = b_zero ? '0 : {1'b1, fb, 3'b000};
      mag_a  = a_zero ? '0 : {ea, fa};
      mag_b  = b_zero ? '0 : {eb, fb};
      swap   = (mag_b > mag_a);
      big_sign   = swap ? sb : sa;
      small_sign = swap ? sa : sb;
      big_exp    = swap ? eb : ea;
      small_exp  = swap ? ea : eb;
      big_sig    = swap ? sig_b : sig_a;
      small_sig  = swap ? sig_a : sig_b;
      ed         = big_exp - small_exp;
      lost_mask  = (SW'(1) << ed) - SW'(1);
      // Past FW+3 positions the smaller operand only survives as a sticky bit.
      if (int'(ed) >= FW + 3) begin
         small_shift = {{(SW-1){1'b0}}, (small_sig != '0)};
      end else begin
         small_shift = (small_sig >> ed) | {{(SW-1){1'b0}}, ((small_sig & lost_mask) != '0)};
      end
      nan_in = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
      inf_in = a_inf || b_inf;
      special_word = nan_in ? QNAN : {(a_inf ? sa : sb), EXP_ONES, {FW{1'b0}}};
   end

   logic          s1_valid_reg, s1_sign_reg, s1_sub_reg, s1_special_reg;
   logic [EW-1:0] s1_exp_reg;
   logic [SW-1:0] s1_siga_reg, s1_sigb_reg;
   logic [W-1:0]  s1_special_word_reg;

   // ---------------- stage 2: add/subtract and normalise ----------------
   logic [SW:0]   sum;
   logic [LW-1:0] lz;
   logic [SW-1:0] norm_sig;
   logic signed [XW-1:0] norm_exp;
   logic          zero_next, sign_next;

   always_comb begin
      sum = s1_sub_reg ? ({1'b0, s1_siga_reg} - {1'b0, s1_sigb_reg})
                       : ({1'b0, s1_siga_reg} + {1'b0, s1_sigb_reg});
      lz = LW'(SW);
      for (int i = 0; i < SW; i++) begin
         if (sum[i]) lz = LW'(SW - 1 - i);
      end
      if (sum[SW]) begin
         norm_sig = sum[SW:1] | {{(SW-1){1'b0}}, sum[0]};
         norm_exp = $signed({2'b00, s1_exp_reg}) + XW'(1);
      end else begin
         norm_sig = sum[SW-1:0] << lz;
         norm_exp = $signed({2'b00, s1_exp_reg}) - $signed(XW'(lz));
      end
      zero_next = (sum == '0);
      // True cancellation yields +0; like-signed zeros keep their sign.
      sign_next = (zero_next && s1_sub_reg) ? 1'b0 : s1_sign_reg;
   end

   logic          s2_valid_reg, s2_sign_reg, s2_zero_reg, s2_special_reg;
   logic signed [XW-1:0] s2_exp_reg;
   logic [SW-1:0] s2_sig_reg;
   logic [W-1:0]  s2_special_word_reg;

   // ---------------- stage 3: round to nearest even and pack ----------------
   logic          round_up;
   logic [FW+1:0] rnd;
   logic [FW-1:0] frac_out;
   logic signed [XW-1:0] exp_out;
   logic [W-1:0]  result;

   always_comb begin
      round_up = s2_sig_reg[2] && (s2_sig_reg[1] || s2_sig_reg[0] || s2_sig_reg[3]);
      rnd      = {1'b0, s2_sig_reg[SW-1:3]} + (FW+2)'(round_up);
      if (rnd[FW+1]) begin
         frac_out = rnd[FW:1];
         exp_out  = s2_exp_reg + XW'(1);
      end else begin
         frac_out = rnd[FW-1:0];
         exp_out  = s2_exp_reg;
      end
      if (s2_special_reg) begin
         result = s2_special_word_reg;
      end else if (s2_zero_reg || (exp_out <= 0)) begin
         result = {s2_sign_reg, {(W-1){1'b0}}};
      end else if (exp_out >= EXP_INF) begin
         result = {s2_sign_reg, EXP_ONES, {FW{1'b0}}};
      end else begin
         result = {s2_sign_reg, exp_out[EW-1:0], frac_out};
      end
   end

   logic         pushout_reg;
   logic [W-1:0] r_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         pushout_reg  <= 1'b0;
         r_reg        <= '0;
      end else if (advance) begin
         s1_valid_reg <= bus.pushin;
         s2_valid_reg <= s1_valid_reg;
         pushout_reg  <= s2_valid_reg;
         r_reg        <= result;
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign_reg         <= big_sign;
         s1_sub_reg          <= (big_sign != small_sign);
         s1_exp_reg          <= big_exp;
         s1_siga_reg         <= big_sig;
         s1_sigb_reg         <= small_shift;
         s1_special_reg      <= nan_in || inf_in;
         s1_special_word_reg <= special_word;
         s2_sign_reg         <= sign_next;
         s2_zero_reg         <= zero_next;
         s2_exp_reg          <= norm_exp;
         s2_sig_reg          <= norm_sig;
         s2_special_reg      <= s1_special_reg;
         s2_special_word_reg <= s1_special_word_reg;
      end
   end

   assign bus.pushout = pushout_reg;
   assign bus.r       = r_reg;
endmodule
